// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared dimensions and state type for the 4x4 matrix multiply sequencer
package matrix_pkg;
    localparam int MAT_DIM   = 4;
    localparam int MAT_ELEMS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/matrix_mul_sequencer_if.sv
// rtl/matrix_mul_sequencer_if.sv - operand/result handshake bundle for matrix_mul_sequencer
interface matrix_mul_sequencer_if
    import matrix_pkg::*;
#(
    parameter int WII = 8,
    parameter int WIF = 8,
    parameter int WOI = 8,
    parameter int WOF = 8
);
    localparam int WI = WII + WIF;
    localparam int WO = WOI + WOF;

    logic                           in_valid;
    logic                           in_ready;
    logic [MAT_ELEMS-1:0][WI-1:0]   matA;
    logic [MAT_ELEMS-1:0][WI-1:0]   matB;
    logic                           out_valid;
    logic                           out_ready;
    logic [MAT_ELEMS-1:0][WO-1:0]   res_mat;
    logic                           busy;

    modport master (
        output in_valid, matA, matB, out_ready,
        input  in_ready, out_valid, res_mat, busy
    );

    modport slave (
        input  in_valid, matA, matB, out_ready,
        output in_ready, out_valid, res_mat, busy
    );
endinterface

// File: rtl/dot_product.sv
// rtl/dot_product.sv - 4-term signed fixed-point dot product, WII.WIF inputs to WOI.WOF result
// Assumes 2*WIF > WOF so each product is narrowed with a round-half-up shift.
module dot_product
    import matrix_pkg::*;
#(
    parameter int WII = 8,
    parameter int WIF = 8,
    parameter int WOI = 8,
    parameter int WOF = 8
) (
    input  logic [MAT_DIM-1:0][WII+WIF-1:0] a_row,
    input  logic [MAT_DIM-1:0][WII+WIF-1:0] b_col,
    output logic [WOI+WOF-1:0]              dot
);
    localparam int WI = WII + WIF;
    localparam int WO = WOI + WOF;
    localparam int PW = 2 * WI;
    localparam int SH = 2 * WIF - WOF;
    localparam logic [PW-1:0] HALF = PW'(1) << (SH - 1);

    logic [MAT_DIM-1:0][WO-1:0] term;
    logic [WO-1:0]              sum01;
    logic [WO-1:0]              sum012;

    for (genvar k = 0; k < MAT_DIM; k++) begin : g_term
        logic [PW-1:0] a_ext;
        logic [PW-1:0] b_ext;
        logic [PW-1:0] prod;

        assign a_ext = {{WI{a_row[k][WI-1]}}, a_row[k]};
        assign b_ext = {{WI{b_col[k][WI-1]}}, b_col[k]};
        assign prod  = a_ext * b_ext;
        // Integer overflow wraps: only the low WO bits of the rounded value survive.
        assign term[k] = WO'((prod + HALF) >> SH);
    end

    assign sum01  = term[0] + term[1];
    assign sum012 = sum01 + term[2];
    assign dot    = sum012 + term[3];
endmodule

// File: rtl/matrix_mul_sequencer.sv
// rtl/matrix_mul_sequencer.sv - 4x4 fixed-point matrix product, one element per cycle on a shared dot unit
module matrix_mul_sequencer
    import matrix_pkg::*;
#(
    parameter int WII = 8,
    parameter int WIF = 8,
    parameter int WOI = 8,
    parameter int WOF = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_mul_sequencer_if.slave   bus
);
    localparam int WI = WII + WIF;
    localparam int WO = WOI + WOF;

    state_t                         state;
    state_t                         state_d;
    logic [3:0]                     idx;
    logic [3:0]                     idx_d;
    logic                           load;
    logic [MAT_ELEMS-1:0][WI-1:0]   a_q;
    logic [MAT_ELEMS-1:0][WI-1:0]   b_q;
    logic [MAT_ELEMS-1:0][WO-1:0]   res_q;
    logic [MAT_DIM-1:0][WI-1:0]     a_row;
    logic [MAT_DIM-1:0][WI-1:0]     b_col;
    logic [WO-1:0]                  dot;

    always_comb begin
        for (int k = 0; k < MAT_DIM; k++) begin
            a_row[k] = a_q[{idx[3:2], 2'(k)}];
            b_col[k] = b_q[{2'(k), idx[1:0]}];
        end
    end

    dot_product #(
        .WII (WII),
        .WIF (WIF),
        .WOI (WOI),
        .WOF (WOF)
    ) u_dot (
        .a_row (a_row),
        .b_col (b_col),
        .dot   (dot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (load) begin
                a_q <= bus.matA;
                b_q <= bus.matB;
            end
            if (state == RUN) begin
                res_q[idx] <= dot;
            end
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                idx_d = idx + 4'd1;
                if (idx == 4'(MAT_ELEMS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE first keeps a DONE handshake and a new accept in separate cycles.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.res_mat   = res_q;
    end
endmodule

// File: tb/tb_matrix_mul_sequencer.sv
// tb/tb_matrix_mul_sequencer.sv - directed table-driven bench for matrix_mul_sequencer
module tb_matrix_mul_sequencer;
    typedef logic [15:0][15:0] mat_t;

    typedef struct {
        mat_t a;
        mat_t b;
        mat_t exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    matrix_mul_sequencer_if #(.WII(8), .WIF(8), .WOI(8), .WOF(8)) bus ();

    matrix_mul_sequencer #(.WII(8), .WIF(8), .WOI(8), .WOF(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    function automatic mat_t fill(input logic [15:0] v);
        mat_t m;
        for (int k = 0; k < 16; k++) m[k] = v;
        return m;
    endfunction

    function automatic mat_t diag(input logic [15:0] v);
        mat_t m;
        m = '0;
        m[0] = v; m[5] = v; m[10] = v; m[15] = v;
        return m;
    endfunction

    function automatic mat_t ramp(input int sh);
        mat_t m;
        for (int k = 0; k < 16; k++) m[k] = 16'(k) << sh;
        return m;
    endfunction

    function automatic mat_t rows(input logic [15:0] r0, r1, r2, r3);
        mat_t m;
        for (int k = 0; k < 4; k++) begin
            m[k] = r0; m[4+k] = r1; m[8+k] = r2; m[12+k] = r3;
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input mat_t a, input mat_t b, input mat_t exp, input string name);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.matA = a;
        bus.matB = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({name, " busy"}, 256'(bus.busy), 256'(1));
        wait_done(n);
        chk({name, " latency"}, 256'(n), 256'(16));
        chk({name, " res_mat"}, 256'(bus.res_mat), 256'(exp));
        @(negedge clk);
        chk({name, " in_ready after handshake"}, 256'(bus.in_ready), 256'(1));
        chk({name, " out_valid after handshake"}, 256'(bus.out_valid), 256'(0));
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.matA = '0;
        bus.matB = '0;

        vecs[0] = '{diag(16'h0100), ramp(8),         ramp(8)};
        vecs[1] = '{diag(16'h0200), fill(16'h0100),  fill(16'h0200)};
        vecs[2] = '{fill(16'h0100), fill(16'h0100),  fill(16'h0400)};
        vecs[3] = '{fill(16'hFF00), fill(16'h0100),  fill(16'hFC00)};
        vecs[4] = '{diag(16'h0080), ramp(8),         ramp(7)};
        vecs[5] = '{fill(16'h0001), diag(16'h0080),  fill(16'h0001)};
        vecs[6] = '{fill(16'hFFFF), diag(16'h0080),  fill(16'h0000)};
        vecs[7] = '{diag(16'h4000), diag(16'h0300),  diag(16'hC000)};
        vecs[8] = '{fill(16'h2000), fill(16'h0100),  fill(16'h8000)};
        vecs[9] = '{ramp(8),        fill(16'h0100),  rows(16'h0600, 16'h1600, 16'h2600, 16'h3600)};

        repeat (2) @(negedge clk);
        chk("reset in_ready", 256'(bus.in_ready), 256'(1));
        chk("reset out_valid", 256'(bus.out_valid), 256'(0));
        chk("reset busy", 256'(bus.busy), 256'(0));
        chk("reset res_mat", 256'(bus.res_mat), 256'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for five cycles.
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.matA = fill(16'h0100);
        bus.matB = fill(16'h0100);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(n);
        chk("bp latency", 256'(n), 256'(16));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp out_valid c%0d", c), 256'(bus.out_valid), 256'(1));
            chk($sformatf("bp in_ready c%0d", c), 256'(bus.in_ready), 256'(0));
            chk($sformatf("bp res_mat c%0d", c), 256'(bus.res_mat), 256'(fill(16'h0400)));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp released in_ready", 256'(bus.in_ready), 256'(1));
        chk("bp released out_valid", 256'(bus.out_valid), 256'(0));

        // Operand isolation: new operands and an in_valid pulse at idx 5.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.matA = diag(16'h0100);
        bus.matB = ramp(8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        bus.matA = fill(16'h7F00);
        bus.matB = fill(16'h1234);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(n);
        chk("iso latency", 256'(n), 256'(10));
        chk("iso res_mat", 256'(bus.res_mat), 256'(ramp(8)));
        @(negedge clk);
        chk("iso in_ready", 256'(bus.in_ready), 256'(1));
        @(negedge clk);
        chk("iso no second accept", 256'(bus.busy), 256'(0));

        // Reset in the middle of a run at idx 7.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.matA = diag(16'h0200);
        bus.matB = fill(16'h0100);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 256'(bus.out_valid), 256'(0));
        chk("midrst in_ready", 256'(bus.in_ready), 256'(1));
        chk("midrst busy", 256'(bus.busy), 256'(0));
        chk("midrst res_mat", 256'(bus.res_mat), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(diag(16'h0100), ramp(8), ramp(8), "post_reset");

        // Back-to-back with in_valid held high.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.matA = fill(16'h0100);
        bus.matB = fill(16'h0100);
        @(negedge clk);
        bus.matA = diag(16'h0100);
        bus.matB = ramp(8);
        wait_done(n);
        chk("b2b first latency", 256'(n), 256'(16));
        chk("b2b first res_mat", 256'(bus.res_mat), 256'(fill(16'h0400)));
        @(negedge clk);
        chk("b2b handshake in_ready", 256'(bus.in_ready), 256'(1));
        chk("b2b handshake busy", 256'(bus.busy), 256'(0));
        @(negedge clk);
        chk("b2b second accept busy", 256'(bus.busy), 256'(1));
        wait_done(n);
        bus.in_valid = 1'b0;
        chk("b2b second latency", 256'(n), 256'(16));
        chk("b2b second res_mat", 256'(bus.res_mat), 256'(ramp(8)));
        @(negedge clk);
        chk("b2b end in_ready", 256'(bus.in_ready), 256'(1));
        @(negedge clk);
        chk("b2b end busy", 256'(bus.busy), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matrix_mul_sequencer.md
MATRIX_MUL_SEQUENCER -- requirements
Module: matrix_mul_sequencer

Interface
REQ-001 SHALL have parameter WII, default 8, meaning input element integer bits.
REQ-002 SHALL have parameter WIF, default 8, meaning input element fraction bits.
REQ-003 SHALL have parameter WOI, default 8, meaning output element integer bits.
REQ-004 SHALL have parameter WOF, default 8, meaning output element fraction bits.
REQ-005 SHALL have port clk  input  1  meaning single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  meaning matA/matB operands valid.
REQ-008 SHALL have port in_ready  output  1  meaning sequencer can accept operands.
REQ-009 SHALL have port matA  input  16 x (WII+WIF)  meaning left 4x4 matrix, row-major, element 0 top-left.
REQ-010 SHALL have port matB  input  16 x (WII+WIF)  meaning right 4x4 matrix, same layout.
REQ-011 SHALL have port out_valid  output  1  meaning res_mat holds a complete product.
REQ-012 SHALL have port out_ready  input  1  meaning consumer accepts res_mat.
REQ-013 SHALL have port res_mat  output  16 x (WOI+WOF)  meaning product matA x matB, row-major.
REQ-014 SHALL have port busy  output  1  meaning state is not IDLE.

Function
REQ-015 SHALL compute the 4x4 product time-multiplexed over one shared 4-term dot-product unit, one result element per cycle.
REQ-016 SHALL implement states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 SHALL, on an edge with in_valid && in_ready, register matA and matB into internal operand registers, clear element counter idx to 0, and enter RUN.
REQ-018 SHALL, on each RUN edge, write res_mat[idx] = dot(row idx[3:2] of latched A, column idx[1:0] of latched B), then increment idx.
REQ-019 SHALL, on the RUN edge writing idx == 15, enter DONE; idx wraps to 0.
REQ-020 SHALL give fixed latency: accept edge E0, element writes at E1..E16, out_valid high from E16 onward; 16 compute cycles, no early exit.
REQ-021 SHALL, in DONE, hold res_mat and out_valid stable until an edge with out_ready high, then enter IDLE.
REQ-022 SHALL NOT accept new operands in the same cycle as a DONE handshake; next acceptance earliest one cycle later (throughput 1 product / 18 cycles minimum).
REQ-023 SHALL ignore in_valid and changes on matA/matB while in RUN or DONE; results depend only on latched operands.
REQ-024 SHALL use, per element, signed fixed-point multiply to WOI.WOF with rounding, then three sequential WOI.WOF rounding adds (order: p0+p1, +p2, +p3), overflow truncated as in existing fixed-point primitives; overflow not reported.
REQ-025 SHALL leave res_mat elements not yet written in the current RUN at their prior values (undefined to consumers until out_valid).

Reset
REQ-026 SHALL, while rst_n low, force state IDLE, idx 0, in_ready 1, out_valid 0, busy 0, res_mat all zero, operand registers zero.
REQ-027 SHALL abandon any RUN/DONE operation on reset assertion; no partial result is ever presented with out_valid.

Structure
REQ-028 SHALL place MAT_DIM = 4, MAT_ELEMS = 16, and the state enum type in shared package matrix_pkg.
REQ-029 SHALL instantiate exactly one dot_product sub-module (WII/WIF/WOI/WOF passed through), fed by row/column muxes from idx.
REQ-030 SHALL keep all registers in one always_ff with asynchronous active-low reset; next-state logic combinational.

Verification
REQ-031 Identity: A = diag(0x0100), B element k = k<<8, out_ready high -> out_valid at E16, res_mat[k] = k<<8, returns to IDLE at E17.
REQ-032 Scale: A = diag(0x0200), B all 0x0100 -> every res_mat element 0x0200; with A all 0x0100 -> every element 0x0400.
REQ-033 Backpressure: out_ready low 5 cycles after DONE -> out_valid and res_mat stable 5 cycles, in_ready low; accept on 6th -> IDLE next edge.
REQ-034 Operand isolation: change matA/matB and pulse in_valid during RUN at idx 5 -> result equals product of originally latched operands, no second acceptance.
REQ-035 Reset mid-run: assert rst_n low at idx 7 -> out_valid 0, in_ready 1, res_mat zero; next operation (identity case) yields correct result at E16.
REQ-036 Back-to-back: in_valid held high through two operations -> second acceptance exactly one cycle after first DONE handshake, both results correct.
